vec_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4-to-1 vector result multiplexer (`mux_4to1`), which selects between one 192-bit vector source and three 32-bit scalar sources. The block grants one requester at a time and drives the mux `sel` input. It also owns the valid/ready handshake toward the downstream register-file writeback port and enforces a per-tenure burst limit so that no source can starve the others.

---
 rtl/vec_bus_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 25 ++
 rtl/vec_bus_arbiter.sv | 96 +++++++++
 tb/tb_vec_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_bus_pkg.sv
// Shared widths, source IDs and FSM encoding for the vector result mux arbiter.
package vec_bus_pkg;
  localparam int N_SRC  = 4;
  localparam int SEL_W  = 2;
  localparam int VEC_W  = 192;
  localparam int WORD_W = 32;

  localparam logic [SEL_W-1:0] SRC_VEC = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B   = 2'd1;
  localparam logic [SEL_W-1:0] SRC_C   = 2'd2;
  localparam logic [SEL_W-1:0] SRC_D   = 2'd3;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set req bit starting at ptr, wrapping mod 4.
// Purely combinational, zero latency, no backpressure.
module rr_priority_pick
  import vec_bus_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_SRC-1:0] oh
);
  // Walk from the lowest-priority offset down so the ptr slot is written last and wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        any = 1'b1;
        idx = ptr + SEL_W'(i);
      end
    end
    if (any) oh[idx] = 1'b1;
  end
endmodule

// File: rtl/vec_bus_arbiter.sv
// Round-robin grant/sel sequencer for the 4-to-1 vector result mux with per-tenure burst cap.
// Grant one cycle after request; zero-bubble handover; ready=0 holds grant, sel and beat count.
module vec_bus_arbiter
  import vec_bus_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] last,
  input  logic             ready,
  output logic [N_SRC-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             busy
);
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt, pick_ptr, pick_idx;
  logic [N_SRC-1:0] gnt_nxt, pick_oh;
  logic [3:0]       beat_cnt, cnt_nxt;
  logic             busy_nxt, beat, rel, pick_any;

  assign valid = (state == GRANT) && req[sel];
  assign beat  = valid && ready;
  assign rel   = (state == GRANT) &&
                 (!req[sel] || (beat && (last[sel] || (beat_cnt + 4'd1 == BURST_LIM))));

  // On release the search starts just past the grantee, which puts it last in line.
  assign pick_ptr = rel ? sel + SEL_W'(1) : ptr;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx),
    .oh  (pick_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= SRC_VEC;
      busy     <= 1'b0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    ptr_nxt   = ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = pick_oh;
          sel_nxt   = pick_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt = pick_ptr;
          cnt_nxt = '0;
          if (pick_any) begin
            gnt_nxt = pick_oh;
            sel_nxt = pick_idx;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end else if (beat) begin
          cnt_nxt = beat_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vec_bus_arbiter.sv
// Directed scenarios plus a randomized run against a rule-level reference model of the arbiter.
module tb_vec_bus_arbiter;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, last;
  logic       ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid, busy;

  int checks = 0;
  int failures = 0;

  // Reference model state: who holds the bus, how many beats so far, where the search starts.
  bit m_idle = 1'b1;
  int m_sel = 0;
  int m_cnt = 0;
  int m_ptr = 0;
  int beat_q[$];

  vec_bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .last  (last),
    .ready (ready),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (!m_idle) g[m_sel] = 1'b1;
    return g;
  endfunction

  function automatic logic m_valid();
    return !m_idle && req[m_sel];
  endfunction

  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] lst, input logic rdy);
    @(negedge clk);
    rst = r; req = rq; last = lst; ready = rdy;
    #1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then let the DUT clock.
  task automatic tick();
    int w;
    bit bt, rl;
    if (rst) begin
      m_idle = 1'b1; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_idle) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_idle = 1'b0; m_sel = w; m_cnt = 0; end
    end else begin
      bt = req[m_sel] && ready;
      rl = !req[m_sel] || (bt && (last[m_sel] || (m_cnt + 1 == MB)));
      if (bt) beat_q.push_back(m_sel);
      if (rl) begin
        m_ptr = (m_sel + 1) % 4;
        m_cnt = 0;
        w = pick(req, m_ptr);
        if (w >= 0) m_sel = w;
        else m_idle = 1'b1;
      end else if (bt) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    beat_q.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 4'b1111, 4'b0000, 1'b1);
      tick();
      checks++;
      if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_regs[%0d] gnt=%b sel=%b busy=%b expected 0000/00/0", c, gnt, sel, busy);
      end
      checks++;
      if (valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid[%0d] got=%b expected=0", c, valid);
      end
    end
    apply(1'b0, 4'b1111, 4'b0000, 1'b0);
    tick();
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant gnt=%b sel=%b busy=%b expected 0001/00/1", gnt, sel, busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_sel[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 4'b1111, 4'b1111, 1'b1);
      tick();
      checks++;
      if (sel !== 2'(exp_sel[k]) || busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_sel[%0d] sel=%0d busy=%b expected sel=%0d busy=1", k, sel, busy, exp_sel[k]);
      end
    end
    checks++;
    if (beat_q.size() != 4 || beat_q[0] != 0 || beat_q[1] != 1 || beat_q[2] != 2 || beat_q[3] != 3) begin
      failures++;
      $display("FAIL rr_beats got=%p expected='{0,1,2,3}", beat_q);
    end
  endtask

  task automatic test_burst_limit();
    int exp_src[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    apply(1'b0, 4'b0011, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 9; k++) begin
      apply(1'b0, 4'b0011, 4'b0000, 1'b1);
      checks++;
      if (valid !== 1'b1 || sel !== 2'(exp_src[k])) begin
        failures++;
        $display("FAIL burst_beat[%0d] valid=%b sel=%0d expected valid=1 sel=%0d", k, valid, sel, exp_src[k]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    apply(1'b0, 4'b0100, 4'b0000, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 4'b0101, 4'b0000, 1'b0);
      checks++;
      if (valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_valid[%0d] got=%b expected=1", k, valid);
      end
      tick();
      checks++;
      if (sel !== 2'b10 || gnt !== 4'b0100 || dut.beat_cnt !== 4'd0) begin
        failures++;
        $display("FAIL stall_hold[%0d] sel=%b gnt=%b cnt=%0d expected 10/0100/0", k, sel, gnt, dut.beat_cnt);
      end
    end
    apply(1'b0, 4'b0101, 4'b0100, 1'b1);
    tick();
    checks++;
    if (sel !== 2'b00 || beat_q.size() != 1 || beat_q[0] != 2) begin
      failures++;
      $display("FAIL stall_release sel=%b beats=%p expected sel=00 beats='{2}", sel, beat_q);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    apply(1'b0, 4'b0010, 4'b0000, 1'b0);
    tick();
    apply(1'b0, 4'b1000, 4'b0000, 1'b1);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_valid got=%b expected=0", valid);
    end
    tick();
    checks++;
    if (sel !== 2'b11 || gnt !== 4'b1000 || dut.ptr !== 2'b10) begin
      failures++;
      $display("FAIL withdraw_handover sel=%b gnt=%b ptr=%b expected 11/1000/10", sel, gnt, dut.ptr);
    end
    do_reset();
    apply(1'b0, 4'b0010, 4'b0000, 1'b0);
    tick();
    apply(1'b0, 4'b0000, 4'b0000, 1'b1);
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || dut.ptr !== 2'b10) begin
      failures++;
      $display("FAIL withdraw_idle gnt=%b busy=%b ptr=%b expected 0000/0/10", gnt, busy, dut.ptr);
    end
  endtask

  task automatic test_reset_mid_tenure();
    do_reset();
    apply(1'b0, 4'b1000, 4'b0000, 1'b1);
    tick();
    apply(1'b0, 4'b1000, 4'b0000, 1'b1);
    tick();
    apply(1'b1, 4'b1000, 4'b0000, 1'b1);
    tick();
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || dut.ptr !== 2'b00 || dut.beat_cnt !== 4'd0) begin
      failures++;
      $display("FAIL midrst_regs gnt=%b sel=%b busy=%b ptr=%b cnt=%0d expected all zero",
               gnt, sel, busy, dut.ptr, dut.beat_cnt);
    end
    apply(1'b0, 4'b1000, 4'b0000, 1'b1);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valid got=%b expected=0", valid);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'b11) begin
      failures++;
      $display("FAIL midrst_regrant gnt=%b sel=%b expected 1000/11", gnt, sel);
    end
  endtask

  task automatic test_random();
    logic r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 49) == 0);
      apply(r, 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      checks++;
      if (valid !== m_valid()) begin
        failures++;
        $display("FAIL rand_valid[%0d] got=%b expected=%b", k, valid, m_valid());
      end
      tick();
      checks++;
      if (gnt !== m_gnt() || busy !== !m_idle || dut.ptr !== 2'(m_ptr)) begin
        failures++;
        $display("FAIL rand_state[%0d] gnt=%b busy=%b ptr=%0d expected %b/%b/%0d",
                 k, gnt, busy, dut.ptr, m_gnt(), !m_idle, m_ptr);
      end
      if (!m_idle) begin
        checks++;
        if (sel !== 2'(m_sel) || dut.beat_cnt !== 4'(m_cnt)) begin
          failures++;
          $display("FAIL rand_sel[%0d] sel=%0d cnt=%0d expected %0d/%0d", k, sel, dut.beat_cnt, m_sel, m_cnt);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; last = 4'b0000; ready = 1'b0;
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_stall();
    test_withdraw();
    test_reset_mid_tenure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
